// File: rtl/upsampler_feeder_pkg.sv
// Shared definitions for the upsampler feeder: state encoding, default sample
// width and the saturating narrowing helper used by the gain stage.
package feeder_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } feeder_state_t;

  // Clamp a DW+9 bit signed value into the DW bit signed range.
  function automatic logic signed [DW_DEFAULT-1:0] sat_dw(input logic signed [DW_DEFAULT+8:0] v);
    logic signed [DW_DEFAULT+8:0] max_v;
    logic signed [DW_DEFAULT+8:0] min_v;
    max_v = {{10{1'b0}}, {(DW_DEFAULT-1){1'b1}}};
    min_v = {{10{1'b1}}, {(DW_DEFAULT-1){1'b0}}};
    if (v > max_v) begin
      return max_v[DW_DEFAULT-1:0];
    end else if (v < min_v) begin
      return min_v[DW_DEFAULT-1:0];
    end
    return v[DW_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/upsampler_feeder_if.sv
// Valid/ready sample stream from the SoC side into the feeder.
interface upsampler_feeder_if #(parameter int DW = 16) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/upsampler_feeder_sync_fifo_ptr.sv
// Single-clock FIFO with extra-MSB pointers; storage is a plain array with a
// registered read so it maps onto block RAM.
module sync_fifo_ptr #(
  parameter int DEPTH = 64,
  parameter int DW    = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [DW-1:0] rd_data_reg;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    if (pop)  rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  assign rd_data    = rd_data_reg;
  assign fill_level = wr_ptr_reg - rd_ptr_reg;
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
endmodule

// File: rtl/upsampler_feeder.sv
// Rate-paced sample source for the upsampler: primes a FIFO, then releases one
// sample per divider tick. Optional output gain stage under FEEDER_GAIN_EN.
module upsampler_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int PRIME_LEVEL = 16,
  parameter int DW          = DW_DEFAULT
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [15:0]            rate_div,
  input  logic                   hold_on_underflow,
  input  logic [7:0]             gain,
  upsampler_feeder_if.slave      s,
  output logic signed [DW-1:0]   sample_out,
  output logic                   sample_tick,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [15:0]            underflow_cnt,
  output logic [1:0]             state_out
);
  feeder_state_t        state_reg, state_next;
  logic [15:0]          div_reg, period_reg;
  logic                 tick, push, pop, underflow, full, empty, flush;
  logic                 tick_d1_reg, uf_d1_reg;
  logic [DW-1:0]        rd_data;
  logic signed [DW-1:0] scaled;
  logic signed [DW-1:0] sample_out_reg;
  logic                 sample_tick_reg;
  logic [15:0]          underflow_cnt_reg;

  assign flush     = !enable;
  assign s.s_ready = rst_n && enable && !full;
  assign push      = s.s_valid && s.s_ready;
  assign tick      = (state_reg == ST_RUN) && enable && (div_reg == period_reg);
  assign pop       = tick && !empty;
  assign underflow = tick && empty;

  sync_fifo_ptr #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .wr_data    (s.s_data),
    .pop        (pop),
    .rd_data    (rd_data),
    .fill_level (fill_level),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: if (int'(fill_level) >= PRIME_LEVEL || full) state_next = ST_RUN;
        ST_RUN:   state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // The period is resampled only at a wrap so a rate change never truncates
  // the interval already in progress.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg    <= '0;
      period_reg <= '0;
    end else if (state_reg != ST_RUN || !enable || tick) begin
      div_reg    <= '0;
      period_reg <= rate_div;
    end else begin
      div_reg    <= div_reg + 16'd1;
    end
  end

`ifdef FEEDER_GAIN_EN
  logic signed [DW+8:0] product;
  assign product = $signed({{9{rd_data[DW-1]}}, rd_data}) * $signed({{(DW+1){1'b0}}, gain});
  assign scaled  = sat_dw(product >>> 7);
`else
  logic gain_unused;
  assign gain_unused = ^gain;
  assign scaled      = rd_data;
`endif

  // Stage 1 marks the tick while the FIFO read lands; stage 2 publishes it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d1_reg       <= 1'b0;
      uf_d1_reg         <= 1'b0;
      sample_out_reg    <= '0;
      sample_tick_reg   <= 1'b0;
      underflow_cnt_reg <= '0;
    end else if (!enable) begin
      tick_d1_reg       <= 1'b0;
      uf_d1_reg         <= 1'b0;
      sample_out_reg    <= '0;
      sample_tick_reg   <= 1'b0;
    end else begin
      tick_d1_reg     <= tick;
      uf_d1_reg       <= underflow;
      sample_tick_reg <= tick_d1_reg;
      if (tick_d1_reg) begin
        if (uf_d1_reg) begin
          if (!hold_on_underflow) sample_out_reg <= '0;
          if (underflow_cnt_reg != 16'hFFFF) underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
        end else begin
          sample_out_reg <= scaled;
        end
      end
    end
  end

  assign sample_out    = sample_out_reg;
  assign sample_tick   = sample_tick_reg;
  assign underflow_cnt = underflow_cnt_reg;
  assign state_out     = state_reg;
endmodule

// File: tb/tb_upsampler_feeder.sv
// Directed bench for upsampler_feeder with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_upsampler_feeder;
  localparam int DEPTH = 64;
  localparam int PRIME_LEVEL = 16;
  localparam int DW = 16;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] rate_div = 16'd0;
  logic        hold_on_underflow = 1'b0;
  logic [7:0]  gain = 8'd128;
  logic signed [DW-1:0] sample_out;
  logic        sample_tick;
  logic [6:0]  fill_level;
  logic [15:0] underflow_cnt;
  logic [1:0]  state_out;

  upsampler_feeder_if #(.DW(DW)) s_if ();

  upsampler_feeder #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL), .DW(DW)) dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .rate_div          (rate_div),
    .hold_on_underflow (hold_on_underflow),
    .gain              (gain),
    .s                 (s_if),
    .sample_out        (sample_out),
    .sample_tick       (sample_tick),
    .fill_level        (fill_level),
    .underflow_cnt     (underflow_cnt),
    .state_out         (state_out)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_q[$];
  int m_state = 0, m_div = 0, m_period = 0, m_out = 0, m_ucnt = 0, m_p1val = 0;
  bit m_tick = 0, m_p1v = 0, m_p1uf = 0;
  int old_size, old_state;
  bit m_push, m_tk;

  function automatic int scaled_model(input int smp);
`ifdef FEEDER_GAIN_EN
    int p;
    p = (smp * int'(gain)) >>> 7;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p;
`else
    return smp;
`endif
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_state = 0; m_div = 0; m_period = 0; m_out = 0; m_ucnt = 0;
      m_tick = 0; m_p1v = 0; m_p1uf = 0;
    end else if (!enable) begin
      m_q.delete();
      m_state = 0; m_div = 0; m_period = int'(rate_div); m_out = 0;
      m_tick = 0; m_p1v = 0; m_p1uf = 0;
    end else begin
      old_size  = m_q.size();
      old_state = m_state;
      m_push = s_if.s_valid && (old_size < DEPTH);
      m_tk   = (old_state == 2) && (m_div == m_period);
      m_tick = m_p1v;
      if (m_p1v) begin
        if (m_p1uf) begin
          if (!hold_on_underflow) m_out = 0;
          if (m_ucnt < 65535) m_ucnt++;
        end else begin
          m_out = scaled_model(m_p1val);
        end
      end
      m_p1v  = m_tk;
      m_p1uf = m_tk && (old_size == 0);
      if (m_tk && old_size != 0) m_p1val = m_q.pop_front();
      if (m_push) m_q.push_back(int'($signed(s_if.s_data)));
      if (old_state == 0) m_state = 1;
      else if (old_state == 1 && (old_size >= PRIME_LEVEL || old_size == DEPTH)) m_state = 2;
      if (old_state != 2 || m_tk) begin
        m_div = 0;
        m_period = int'(rate_div);
      end else begin
        m_div++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    if (rst_n) begin
      chk("sample_tick", sample_tick, m_tick);
      chk("sample_out", $signed(sample_out), m_out);
      chk("fill_level", fill_level, m_q.size());
      chk("state_out", state_out, m_state);
      chk("underflow_cnt", underflow_cnt, m_ucnt);
      chk("s_ready", s_if.s_ready, (enable && m_q.size() < DEPTH) ? 1 : 0);
      if (sample_tick) begin
        tick_seen++;
        $display("tick t=%0t sample_out=%0d fill=%0d ucnt=%0d", $time, sample_out, fill_level, underflow_cnt);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input int v);
    int n;
    n = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 16'(v);
    while (!s_if.s_ready && n < 200) begin
      step();
      n++;
    end
    chk("push_bounded", (n < 200) ? 1 : 0, 1);
    step();
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_tick(input string name, output int val, output int cyc);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge sys_clk);
      n++;
      if (sample_tick) break;
    end
    chk({name, "_seen"}, sample_tick, 1);
    val = int'($signed(sample_out));
    cyc = n;
  endtask

  task automatic wait_ucnt(input string name, input int target);
    int n;
    n = 0;
    while (n < 400 && int'(underflow_cnt) < target) begin
      @(negedge sys_clk);
      n++;
    end
    chk({name, "_cnt"}, underflow_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v, c, acc, first_v, last_v, got;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    enable = 1'b1;
    rate_div = 16'd3;
    hold_on_underflow = 1'b1;
    gain = 8'd128;

    // reset state with enable already high
    #12;
    chk("rst_state", state_out, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_ready", s_if.s_ready, 0);
    chk("rst_ucnt", underflow_cnt, 0);
    @(posedge sys_clk); #3 rst_n = 1'b1;
    step();

    // priming: 15 words keep PRIME, the 16th starts RUN
    for (int i = 0; i < 15; i++) push_word(100 + i);
    repeat (5) step();
    chk("prime_state", state_out, 1);
    chk("prime_no_tick", tick_seen, 0);
    push_word(115);
    wait_tick("first", v, c);
    chk("first_val", v, 100);
    wait_tick("second", v, c);
    chk("second_val", v, 101);
    chk("tick_spacing", c, 4);

    // async reset between edges while running
    @(posedge sys_clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_state", state_out, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_sample", sample_out, 0);
    chk("arst_tick", sample_tick, 0);
    chk("arst_ready", s_if.s_ready, 0);
    @(posedge sys_clk); #3 rst_n = 1'b1;
    #1;
    chk("post_rst_state", state_out, 0);
    chk("post_rst_ucnt", underflow_cnt, 0);
    step();

    // underflow: hold then zero
    for (int i = 0; i < 16; i++) push_word(16'h1234);
    wait_ucnt("uf1", 1);
    chk("uf1_hold", sample_out, 16'sh1234);
    step();
    hold_on_underflow = 1'b0;
    wait_ucnt("uf2", 2);
    chk("uf2_zero", sample_out, 0);

    // flush from RUN with 10 words buffered
    step();
    hold_on_underflow = 1'b1;
    push_word(777);
    rate_div = 16'hFFFF;
    got = 0;
    for (int k = 0; k < 3 && got == 0; k++) begin
      wait_tick("hold_wait", v, c);
      if (v == 777) got = 1;
    end
    chk("pre_flush_val", v, 777);
    step();
    for (int i = 0; i < 10; i++) push_word(200 + i);
    chk("pre_flush_fill", fill_level, 10);
    enable = 1'b0;
    step();
    enable = 1'b1;
    chk("flush_state", state_out, 0);
    chk("flush_fill", fill_level, 0);
    chk("flush_sample", sample_out, 0);
    step();
    chk("reprime_state", state_out, 1);

    // backpressure: 70 offered, 64 accepted, then drain in order
    rate_div = 16'd100;
    acc = 0;
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      s_if.s_data = 16'(1000 + acc);
      if (s_if.s_ready) acc++;
      step();
    end
    s_if.s_valid = 1'b0;
    chk("bp_accepted", acc, 64);
    chk("bp_fill", fill_level, 64);
    chk("bp_ready", s_if.s_ready, 0);
    rate_div = 16'd0;
    wait_tick("drain_first", first_v, c);
    chk("drain_first_val", first_v, 1000);
    last_v = first_v;
    for (int i = 1; i < 64; i++) wait_tick("drain", last_v, c);
    chk("drain_last_val", last_v, 1063);

    // gain stage (ignored when the feature is not built)
    @(posedge sys_clk); #3 rst_n = 1'b0;
    @(posedge sys_clk); #3 rst_n = 1'b1;
    rate_div = 16'd3;
    hold_on_underflow = 1'b0;
    gain = 8'd255;
    step();
    push_word(20000);
    push_word(-20000);
    push_word(1000);
    for (int i = 0; i < 13; i++) push_word(0);
    wait_tick("g1", v, c);
`ifdef FEEDER_GAIN_EN
    chk("gain_pos_sat", v, 32767);
`else
    chk("nogain_pos", v, 20000);
`endif
    wait_tick("g2", v, c);
`ifdef FEEDER_GAIN_EN
    chk("gain_neg_sat", v, -32768);
`else
    chk("nogain_neg", v, -20000);
`endif
    gain = 8'd64;
    wait_tick("g3", v, c);
`ifdef FEEDER_GAIN_EN
    chk("gain_half", v, 500);
`else
    chk("nogain_1000", v, 1000);
`endif
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/upsampler_feeder.md
Name: upsampler_feeder

Overview:
- FIFO-backed sample source for the upsampler side of the DSP chain: the SoC side pushes signed 16-bit samples over a valid/ready stream.
- The block releases exactly one sample per rate tick onto the upsampler input, holding it stable between ticks.
- It is the producer counterpart of the decimated-sample output: it supplies `upsamplerInput`, with priming, underflow handling and optional gain.
- Single clock domain `sys_clk`.

Parameters:
- DEPTH, 64, FIFO entries (power of two, >= 4).
- PRIME_LEVEL, 16, fill level required before RUN starts (1..DEPTH).
- DW, 16, sample width.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; low flushes and idles
- rate_div  in  16  tick period in sys_clk cycles minus 1 (0 = tick every cycle)
- hold_on_underflow  in  1  1: repeat last sample on underflow, 0: output zero
- gain  in  8  unsigned Q1.7, 128 = unity (used only with FEEDER_GAIN_EN)
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready (= FIFO not full)
- s_data  in  DW  signed input sample
- sample_out  out  DW  signed sample to upsampler filter_in
- sample_tick  out  1  one-cycle pulse when sample_out updates
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- underflow_cnt  out  16  saturating underflow counter
- state_out  out  2  FSM state (IDLE=0, PRIME=1, RUN=2)

Behaviour:
- Reset (async, rst_n low): FIFO empty, state IDLE, divider 0, sample_out 0, sample_tick 0, underflow_cnt 0, fill_level 0, s_ready 0 while reset is asserted.
- Push: a word is accepted when s_valid && s_ready. s_ready = !full && enable.
- Simultaneous push and pop when full: the pop frees a slot, but s_ready is computed combinationally from the registered full flag only, so there is no push that cycle.
- FSM:
  - IDLE: divider held at 0. Goes to PRIME when enable=1.
  - PRIME: no pops; sample_out holds its value. Goes to RUN when fill_level >= PRIME_LEVEL or the FIFO is full.
  - RUN: divider counts 0..rate_div and tick fires on wrap. On each tick, pop if non-empty; if empty, underflow.
  - Any state with enable=0 goes to IDLE next cycle. Entering IDLE flushes the FIFO (pointers reset) and sets sample_out to 0 in the same cycle.
  - Re-enable re-primes.
- Underflow (tick with FIFO empty in RUN):
  - No pop; underflow_cnt increments, saturating at 0xFFFF.
  - sample_out = last sample if hold_on_underflow=1, else 0.
  - sample_tick still pulses.
  - State stays RUN; no re-prime.
- Latency:
  - Tick in cycle n: FIFO read registered in n+1, sample_out and sample_tick valid in n+2. This holds whether or not the gain feature is present.
  - A word pushed into an empty FIFO is poppable the cycle after acceptance.
- Divider: a rate_div change takes effect at the next wrap. With rate_div=0 the divider ticks every cycle; pops then sustain 1 sample/cycle while the FIFO is non-empty.
- Pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare, so wrap-around is exact.

Optional Feature:
- Macro: FEEDER_GAIN_EN.
- Defined: sample_out = saturate_DW((sample * gain) >>> 7).
  - The product is signed DW+9 bits.
  - The result clamps to +32767 / -32768.
  - Gain is applied in the n+2 register stage.
- Undefined: gain is ignored, the multiplier is not synthesized, and sample_out = popped sample; latency is still n+2.

Decomposition:
- Shared package `feeder_pkg`: state encoding (IDLE/PRIME/RUN), saturation helper function, DW default.
- One natural sub-module, `sync_fifo_ptr` (parameterised DEPTH/DW): storage, pointers, fill_level, full/empty.
- FSM, divider, gain and counters stay in `upsampler_feeder`.

Test Plan:
- Prime: rate_div=3; push 15 words with enable=1 -> state stays PRIME, no sample_tick. Push a 16th -> RUN, and the first sample_tick arrives with sample_out = word0; ticks follow every 4 cycles, in order.
- Underflow hold: push 16 words of 0x1234 and drain them all. Next tick with hold_on_underflow=1 -> sample_out=0x1234, underflow_cnt=1. With hold=0 -> sample_out=0, underflow_cnt=2.
- Full/backpressure: DEPTH=64, rate_div=0xFFFF; push 70 words continuously -> s_ready drops after 64 accepted, fill_level=64, and no word is lost or overwritten.
- Gain (FEEDER_GAIN_EN): gain=255, sample 20000 -> sample_out=32767. Sample -20000 -> -32768. gain=64, sample 1000 -> 500.
- Flush: in RUN with fill=10, drop enable for 1 cycle -> state IDLE, fill_level 0, sample_out 0. Re-enable -> PRIME.
- Async reset mid-RUN: assert rst_n low between clock edges -> all outputs go to reset values immediately. After release, state IDLE and underflow_cnt 0.
